// File: rtl/change_dispenser.sv
// Greedy change dispenser: returns i_total as coins of three values over a valid/ready coin port.
// Optional per-coin handshake counters are built when CHANGE_COUNT_EN is defined.
module change_dispenser #(
    parameter int unsigned TOTAL_BITS = 31,
    parameter int unsigned COIN0_VAL  = 100,
    parameter int unsigned COIN1_VAL  = 500,
    parameter int unsigned COIN2_VAL  = 1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_total,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [1:0]            o_coin_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_remaining,
    output logic [23:0]           o_coin_count
);

    localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
    localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
    localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPENSE = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_coin_valid;
    logic [1:0]            r_coin_sel;
    logic                  r_busy;
    logic                  r_done;
    logic [TOTAL_BITS-1:0] r_remaining;
    logic [TOTAL_BITS-1:0] w_coin_val;

    // Value of the coin currently held on the coin port.
    always_comb begin
        w_coin_val = '0;
        case (r_coin_sel)
            2'd0:    w_coin_val = C0;
            2'd1:    w_coin_val = C1;
            2'd2:    w_coin_val = C2;
            default: w_coin_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_coin_valid <= 1'b0;
            r_coin_sel   <= 2'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_remaining  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_trigger_return) begin
                        r_remaining <= i_total;
                        r_busy      <= 1'b1;
                        r_state     <= SELECT;
                    end
                end
                SELECT: begin
                    // Largest coin that fits; selection guarantees the later subtraction cannot underflow.
                    if (r_remaining >= C2) begin
                        r_coin_sel   <= 2'd2;
                        r_coin_valid <= 1'b1;
                        r_state      <= DISPENSE;
                    end else if (r_remaining >= C1) begin
                        r_coin_sel   <= 2'd1;
                        r_coin_valid <= 1'b1;
                        r_state      <= DISPENSE;
                    end else if (r_remaining >= C0) begin
                        r_coin_sel   <= 2'd0;
                        r_coin_valid <= 1'b1;
                        r_state      <= DISPENSE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DISPENSE: begin
                    if (i_coin_ready) begin
                        r_remaining  <= r_remaining - w_coin_val;
                        r_coin_valid <= 1'b0;
                        r_state      <= SELECT;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_coin_valid <= 1'b0;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

`ifdef CHANGE_COUNT_EN
    logic [2:0][7:0] r_coin_count;
    logic            w_handshake;
    logic            w_accept;

    assign w_handshake = r_coin_valid & i_coin_ready;
    assign w_accept    = (r_state == IDLE) & i_trigger_return;

    // Saturating per-coin handshake counters, cleared when a new return starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coin_count <= '0;
        end else if (w_accept) begin
            r_coin_count <= '0;
        end else if (w_handshake) begin
            case (r_coin_sel)
                2'd0: if (r_coin_count[0] != 8'hFF) r_coin_count[0] <= r_coin_count[0] + 8'd1;
                2'd1: if (r_coin_count[1] != 8'hFF) r_coin_count[1] <= r_coin_count[1] + 8'd1;
                2'd2: if (r_coin_count[2] != 8'hFF) r_coin_count[2] <= r_coin_count[2] + 8'd1;
                default: ;
            endcase
        end
    end

    assign o_coin_count = r_coin_count;
`else
    assign o_coin_count = 24'd0;
`endif

    assign o_coin_valid = r_coin_valid;
    assign o_coin_sel   = r_coin_sel;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_remaining  = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy-change model queues expected coins and
// completion records; a monitor compares them as the DUT hands over coins and signals done.
module tb_change_dispenser;

    localparam int BOUND = 4000;

    typedef struct {
        logic [30:0] rem;
        logic [23:0] cnt;
    } done_rec_t;

    logic        clk;
    logic        reset_n;
    logic        i_trigger_return;
    logic [30:0] i_total;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [1:0]  o_coin_sel;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_remaining;
    logic [23:0] o_coin_count;

    int        q_coin[$];
    done_rec_t q_done[$];
    int        n_tests;
    int        n_fail;
    int        ready_mode;
    logic      ready_force;

    change_dispenser #(
        .TOTAL_BITS(31), .COIN0_VAL(100), .COIN1_VAL(500), .COIN2_VAL(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_trigger_return(i_trigger_return), .i_total(i_total),
        .i_coin_ready(i_coin_ready), .o_coin_valid(o_coin_valid),
        .o_coin_sel(o_coin_sel), .o_busy(o_busy), .o_done(o_done),
        .o_remaining(o_remaining), .o_coin_count(o_coin_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event outside expectation / bound, required none", name);
    endtask

    function automatic logic [7:0] sat8(input int unsigned n);
        return (n > 255) ? 8'hFF : 8'(n);
    endfunction

    // Greedy change: take as many of the biggest coin as fit, then the next, and so on.
    function automatic int model_push(input int unsigned total);
        int unsigned vals[3] = '{100, 500, 1000};
        int unsigned n[3]    = '{0, 0, 0};
        int unsigned rem     = total;
        int          coins   = 0;
        done_rec_t   r;
        for (int i = 2; i >= 0; i--) begin
            while (rem >= vals[i]) begin
                rem -= vals[i];
                n[i]++;
                coins++;
                q_coin.push_back(i);
            end
        end
        r.rem = 31'(rem);
`ifdef CHANGE_COUNT_EN
        r.cnt = {sat8(n[2]), sat8(n[1]), sat8(n[0])};
`else
        r.cnt = 24'd0;
`endif
        q_done.push_back(r);
        return coins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        done_rec_t r;
        forever begin
            @(negedge clk);
            if (o_coin_valid && i_coin_ready) begin
                if (q_coin.size() == 0) flag_fail("unexpected_coin");
                else check("coin_sel", 64'(o_coin_sel), 64'(q_coin.pop_front()));
            end
            if (o_done) begin
                if (q_done.size() == 0) begin
                    flag_fail("unexpected_done");
                end else begin
                    r = q_done.pop_front();
                    check("done_remaining", 64'(o_remaining), 64'(r.rem));
                    check("done_coin_count", 64'(o_coin_count), 64'(r.cnt));
                    check("done_valid_low", 64'(o_coin_valid), 64'd0);
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #2;
            i_coin_ready = (ready_mode != 0) ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((o_busy || o_done) && k < BOUND) begin
            tick();
            k++;
        end
        if (k >= BOUND) flag_fail("idle_timeout");
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!o_coin_valid && k < BOUND) begin
            tick();
            k++;
        end
        if (k >= BOUND) flag_fail("valid_timeout");
    endtask

    // Latency counts clock edges from the trigger edge (edge 1) to the edge that raises o_done.
    task automatic wait_done(input int exp_lat);
        int lat = 1;
        while (!o_done && lat < BOUND) begin
            tick();
            lat++;
        end
        if (!o_done) flag_fail("done_timeout");
        else if (exp_lat >= 0) check("done_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic start_txn(input int unsigned total, output int coins);
        wait_idle();
        i_total          = 31'(total);
        i_trigger_return = 1'b1;
        coins            = model_push(total);
        tick();
        i_trigger_return = 1'b0;
        i_total          = 31'($urandom);
    endtask

    initial begin
        int nc;
        n_tests          = 0;
        n_fail           = 0;
        ready_mode       = 0;
        ready_force      = 1'b1;
        reset_n          = 1'b0;
        i_trigger_return = 1'b0;
        i_total          = '0;
        i_coin_ready     = 1'b1;
        fork
            monitor();
            ready_driver();
        join_none

        repeat (3) tick();
        check("rst_remaining", 64'(o_remaining), 64'd0);
        check("rst_sel", 64'(o_coin_sel), 64'd0);
        check("rst_valid", 64'(o_coin_valid), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_count", 64'(o_coin_count), 64'd0);

        // First trigger lands on the first edge after reset release: 250 -> two 100 coins, 50 left.
        @(negedge clk);
        reset_n          = 1'b1;
        i_total          = 31'd250;
        i_trigger_return = 1'b1;
        nc               = model_push(250);
        tick();
        i_trigger_return = 1'b0;
        check("busy_first_edge", 64'(o_busy), 64'd1);
        wait_done(2 * nc + 2);

        // A trigger during the o_done cycle must not start a transaction.
        i_total          = 31'd100;
        i_trigger_return = 1'b1;
        tick();
        i_trigger_return = 1'b0;
        check("done_trigger_ignored", 64'(o_busy), 64'd0);
        tick();
        check("still_idle", 64'(o_busy), 64'd0);

        start_txn(1600, nc);
        wait_done(8);
        start_txn(0, nc);
        wait_done(2);

        // Back-pressure: coin 1 held stable while ready is low.
        ready_force = 1'b0;
        start_txn(500, nc);
        wait_valid();
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", 64'(o_coin_valid), 64'd1);
            check("stall_sel", 64'(o_coin_sel), 64'd1);
            check("stall_remaining", 64'(o_remaining), 64'd500);
            tick();
        end
        ready_force = 1'b1;
        wait_done(-1);

        // Retrigger while busy is ignored.
        start_txn(700, nc);
        for (int c = 0; c < 3; c++) begin
            i_total          = 31'd5000;
            i_trigger_return = 1'b1;
            tick();
        end
        i_trigger_return = 1'b0;
        wait_done(-1);

        // Large amount saturates the top coin counter.
        start_txn(300000, nc);
        wait_done(-1);

        // Reset in the middle of a dispense abandons the transaction.
        ready_force = 1'b0;
        start_txn(1000, nc);
        wait_valid();
        tick();
        reset_n = 1'b0;
        #1;
        check("midrst_remaining", 64'(o_remaining), 64'd0);
        check("midrst_sel", 64'(o_coin_sel), 64'd0);
        check("midrst_valid", 64'(o_coin_valid), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_count", 64'(o_coin_count), 64'd0);
        q_coin.delete();
        q_done.delete();
        tick();
        @(negedge clk);
        reset_n     = 1'b1;
        ready_force = 1'b1;
        tick();
        start_txn(100, nc);
        wait_done(4);

        ready_mode = 1;
        for (int t = 0; t < 15; t++) begin
            start_txn($urandom_range(0, 4000), nc);
            wait_done(-1);
        end
        ready_mode = 0;

        wait_idle();
        repeat (3) tick();
        check("coin_queue_empty", 64'(q_coin.size()), 64'd0);
        check("done_queue_empty", 64'(q_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 31, width of the return amount.
REQ-002 SHALL have parameters COIN0_VAL, COIN1_VAL, COIN2_VAL, defaults 100, 500, 1000, coin values in ascending order.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_trigger_return  input  1  request to return the amount on i_total.
REQ-006 SHALL have port i_total  input  TOTAL_BITS  amount to return; sampled only on an accepted trigger.
REQ-007 SHALL have port i_coin_ready  input  1  coin mechanism accepts the presented coin.
REQ-008 SHALL have port o_coin_valid  output  1  a coin is being presented.
REQ-009 SHALL have port o_coin_sel  output  2  presented coin index: 0, 1 or 2; value 3 is never driven.
REQ-010 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port o_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port o_remaining  output  TOTAL_BITS  amount still to be returned.
REQ-013 SHALL have port o_coin_count  output  24  per-coin counts, 8 bits per coin, COIN0 in bits [7:0].

Function
REQ-014 SHALL implement the FSM states IDLE, SELECT, DISPENSE and DONE.
REQ-015 IDLE: trigger high SHALL load o_remaining <= i_total and move to SELECT on the next edge.
REQ-016 SELECT: SHALL pick the highest-indexed coin with value <= o_remaining, register it on o_coin_sel and go to DISPENSE; if no coin fits, SHALL go to DONE.
REQ-017 DISPENSE: o_coin_valid SHALL be 1, and o_coin_sel SHALL be held stable until the handshake.
REQ-018 A handshake SHALL occur when o_coin_valid and i_coin_ready are both 1; on that edge o_remaining SHALL decrease by the coin value and the state SHALL return to SELECT.
REQ-019 With i_coin_ready low, DISPENSE SHALL hold indefinitely; there is no timeout.
REQ-020 DONE: o_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; o_remaining SHALL keep the undispensable residue (< COIN0_VAL).
REQ-021 Trigger while o_busy SHALL be ignored, and i_total changes while busy SHALL have no effect.
REQ-022 i_coin_ready outside DISPENSE SHALL be ignored.
REQ-023 o_coin_valid SHALL be 0 in IDLE, SELECT and DONE.
REQ-024 Subtraction SHALL never underflow, because only coins <= o_remaining are selected.
REQ-025 A trigger in the same cycle as o_done SHALL be ignored (the FSM is not in IDLE).
REQ-026 Total 0 SHALL produce DONE with no coins.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, o_remaining=0, o_coin_sel=0, o_coin_valid=0, o_done=0, o_busy=0 and o_coin_count=0.
REQ-028 Reset asserted mid-dispense SHALL abandon the transaction; no partial coin SHALL be completed.
REQ-029 The first trigger SHALL be honoured on the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro CHANGE_COUNT_EN defined: o_coin_count SHALL increment the selected coin's field on each handshake, saturate at 255 and clear on every accepted trigger.
REQ-031 Macro CHANGE_COUNT_EN undefined: o_coin_count SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-032 Trigger with i_total=1600 and i_coin_ready=1 -> o_coin_sel sequence 2,1,0; o_done at cycle 8 after the trigger edge; o_remaining=0; count=0x010101 (with macro).
REQ-033 i_total=250 -> two coin-0 handshakes; o_done; o_remaining=50.
REQ-034 i_total=0 -> no o_coin_valid; o_done 2 cycles after the trigger edge.
REQ-035 i_total=500, i_coin_ready held low 3 cycles in DISPENSE -> o_coin_valid=1 and o_coin_sel=1 stable all 3 cycles; handshake when ready rises; o_remaining=0.
REQ-036 i_total=1000, reset_n pulsed low during DISPENSE -> outputs zero immediately; a fresh trigger with i_total=100 completes normally.
REQ-037 i_total=700, second trigger with i_total=5000 while busy -> ignored; final o_remaining=0 after coins 1,0,0.
